// File: rtl/csr_file_gen_if.sv
// CSR access bus between the WB stage and the CSR file.
// Groups the read/write port so both sides share one definition.
//   csr_we     : write strobe, qualifies csr_wmask/csr_wdata at the clock edge
//   csr_num    : 14-bit CSR number, used for the read and the write
//   csr_wmask  : per-bit write mask
//   csr_wdata  : write data
//   csr_rdata  : combinational read data of csr_num (0 for unimplemented numbers)
interface csr_file_gen_if;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    output csr_we, csr_num, csr_wmask, csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_we, csr_num, csr_wmask, csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/csr_file_gen.sv
// LoongArch CSR file for the single-issue core, placed beside the WB stage.
// Reads are combinational; writes, exception commit and ertn commit update
// state at the rising clock edge. Includes a configurable SAVE bank, a
// configurable-width timer, BADV capture, LLBCTL/LLBit and a 64-bit counter.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   csr_bus               : CSR read/write bus (slave side)
//   excp_flush/ertn_flush : exception / ertn commit strobes
//   ecode, esubcode, epc  : exception cause and PC, captured on excp_flush
//   va_err, err_va        : BADV capture qualifier and faulting address
//   llbit_set/llbit_clr   : ll.w / sc.w commit
//   llbit, era, eentry    : current LLBit, ERA and EENTRY
//   hard_int_in/ipi_int_in: interrupt lines sampled into ESTAT every cycle
//   has_int               : enabled interrupt pending
//   cnt_value, cnt_id     : stable counter and TID for rdcnt*
module csr_file_gen #(
  parameter int          SAVE_NUM = 4,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_RST  = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  csr_file_gen_if.slave       csr_bus,
  input  logic                excp_flush,
  input  logic                ertn_flush,
  input  logic [5:0]          ecode,
  input  logic [8:0]          esubcode,
  input  logic [31:0]         epc,
  input  logic                va_err,
  input  logic [31:0]         err_va,
  input  logic                llbit_set,
  input  logic                llbit_clr,
  output logic                llbit,
  output logic [31:0]         era,
  output logic [31:0]         eentry,
  input  logic [7:0]          hard_int_in,
  input  logic                ipi_int_in,
  output logic                has_int,
  output logic [63:0]         cnt_value,
  output logic [31:0]         cnt_id
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam int          CSR_SAVE0  = 'h30;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;
  localparam logic [13:0] CSR_LLBCTL = 14'h060;

  logic [8:0]         crmd_q;
  logic [2:0]         prmd_q;
  logic [12:0]        ecfg_q;
  logic [1:0]         estat_sis_q;
  logic [7:0]         estat_hwi_q;
  logic               estat_ti_q;
  logic               estat_ipi_q;
  logic [5:0]         estat_ecode_q;
  logic [8:0]         estat_esub_q;
  logic [31:0]        era_q;
  logic [31:0]        badv_q;
  logic [25:0]        eentry_q;
  logic [31:0]        save_q [SAVE_NUM];
  logic [31:0]        tid_q;
  logic [TIMER_W-1:0] tcfg_q;
  logic [TIMER_W-1:0] tval_q;
  logic               llbit_q;
  logic               klo_q;
  logic [63:0]        cnt_q;

  logic [31:0]        wmask;
  logic [31:0]        wdata;
  logic [TIMER_W-1:0] tcfg_next;
  logic [12:0]        estat_low;
  logic               ertn_eff;
  logic               timer_expire;
  logic               wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv;
  logic               wr_eentry, wr_tid, wr_tcfg, wr_ticlr, wr_llbctl;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] mask,
                                        input logic [31:0] data);
    return (mask & data) | (~mask & old);
  endfunction

  assign wmask     = csr_bus.csr_wmask;
  assign wdata     = csr_bus.csr_wdata;
  assign wr_crmd   = csr_bus.csr_we && (csr_bus.csr_num == CSR_CRMD);
  assign wr_prmd   = csr_bus.csr_we && (csr_bus.csr_num == CSR_PRMD);
  assign wr_ecfg   = csr_bus.csr_we && (csr_bus.csr_num == CSR_ECFG);
  assign wr_estat  = csr_bus.csr_we && (csr_bus.csr_num == CSR_ESTAT);
  assign wr_era    = csr_bus.csr_we && (csr_bus.csr_num == CSR_ERA);
  assign wr_badv   = csr_bus.csr_we && (csr_bus.csr_num == CSR_BADV);
  assign wr_eentry = csr_bus.csr_we && (csr_bus.csr_num == CSR_EENTRY);
  assign wr_tid    = csr_bus.csr_we && (csr_bus.csr_num == CSR_TID);
  assign wr_tcfg   = csr_bus.csr_we && (csr_bus.csr_num == CSR_TCFG);
  assign wr_ticlr  = csr_bus.csr_we && (csr_bus.csr_num == CSR_TICLR);
  assign wr_llbctl = csr_bus.csr_we && (csr_bus.csr_num == CSR_LLBCTL);

  // An exception commit outranks an ertn in the same cycle.
  assign ertn_eff     = ertn_flush && !excp_flush;
  assign tcfg_next    = TIMER_W'(merge(32'(tcfg_q), wmask, wdata));
  // Expiry is evaluated on the current TCFG; a TCFG write that cycle reloads instead.
  assign timer_expire = !wr_tcfg && tcfg_q[0] && (tval_q == '0);
  assign estat_low    = {estat_ipi_q, estat_ti_q, 1'b0, estat_hwi_q, estat_sis_q};

  assign llbit     = llbit_q;
  assign era       = era_q;
  assign eentry    = {eentry_q, 6'b0};
  assign has_int   = crmd_q[2] && |(estat_low & ecfg_q);
  assign cnt_value = cnt_q;
  assign cnt_id    = tid_q;

  // Exception/ertn bookkeeping: CRMD, PRMD, ERA, BADV and ESTAT cause fields.
  // A flush takes the register it touches, so a same-cycle CSR write is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q        <= 9'h008;
      prmd_q        <= '0;
      era_q         <= '0;
      badv_q        <= '0;
      estat_sis_q   <= '0;
      estat_ecode_q <= '0;
      estat_esub_q  <= '0;
    end else begin
      if (excp_flush) begin
        crmd_q[2:0]   <= 3'b000;
        prmd_q        <= crmd_q[2:0];
        era_q         <= epc;
        estat_ecode_q <= ecode;
        estat_esub_q  <= esubcode;
      end else begin
        if (ertn_eff)
          crmd_q[2:0] <= prmd_q;
        else if (wr_crmd)
          crmd_q <= 9'(merge(32'(crmd_q), wmask, wdata));
        if (wr_prmd)
          prmd_q <= 3'(merge(32'(prmd_q), wmask, wdata));
        if (wr_era)
          era_q <= merge(era_q, wmask, wdata);
        if (wr_estat)
          estat_sis_q <= 2'(merge(32'(estat_sis_q), wmask, wdata));
      end
      if (excp_flush && va_err)
        badv_q <= err_va;
      else if (wr_badv)
        badv_q <= merge(badv_q, wmask, wdata);
    end
  end

  // Plain read/write registers and the per-cycle interrupt line sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      ecfg_q      <= '0;
      eentry_q    <= '0;
      tid_q       <= TID_RST;
      estat_hwi_q <= '0;
      estat_ipi_q <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < SAVE_NUM; i++)
        save_q[i] <= '0;
    end else begin
      estat_hwi_q <= hard_int_in;
      estat_ipi_q <= ipi_int_in;
      cnt_q       <= cnt_q + 64'd1;
      if (wr_ecfg)
        ecfg_q <= 13'(merge(32'(ecfg_q), wmask, wdata)) & 13'h1BFF;
      if (wr_eentry)
        eentry_q <= (wmask[31:6] & wdata[31:6]) | (~wmask[31:6] & eentry_q);
      if (wr_tid)
        tid_q <= merge(tid_q, wmask, wdata);
      for (int i = 0; i < SAVE_NUM; i++)
        if (csr_bus.csr_we && (csr_bus.csr_num == 14'(CSR_SAVE0 + i)))
          save_q[i] <= merge(save_q[i], wmask, wdata);
    end
  end

  // Timer: TCFG write reloads, otherwise count down while enabled; on reaching
  // zero raise TI and either reload (periodic) or stop with TVAL held at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q     <= '0;
      tval_q     <= '0;
      estat_ti_q <= 1'b0;
    end else begin
      if (wr_tcfg) begin
        tcfg_q <= tcfg_next;
        tval_q <= {tcfg_next[TIMER_W-1:2], 2'b00};
      end else if (tcfg_q[0] && (tval_q != '0)) begin
        tval_q <= tval_q - 1'b1;
      end else if (tcfg_q[0]) begin
        if (tcfg_q[1])
          tval_q <= {tcfg_q[TIMER_W-1:2], 2'b00};
        else
          tcfg_q[0] <= 1'b0;
      end
      if (timer_expire)
        estat_ti_q <= 1'b1;
      else if (wr_ticlr && wmask[0] && wdata[0])
        estat_ti_q <= 1'b0;
    end
  end

  // LLBit: ertn handling first (KLO keeps the bit once), then sc.w, then
  // a WCLLB write, then ll.w.
  always_ff @(posedge clk) begin
    if (reset) begin
      llbit_q <= 1'b0;
      klo_q   <= 1'b0;
    end else if (ertn_eff) begin
      if (klo_q)
        klo_q <= 1'b0;
      else
        llbit_q <= 1'b0;
    end else begin
      if (llbit_clr)
        llbit_q <= 1'b0;
      else if (wr_llbctl && wmask[1] && wdata[1])
        llbit_q <= 1'b0;
      else if (llbit_set)
        llbit_q <= 1'b1;
      if (wr_llbctl)
        klo_q <= (wmask[2] & wdata[2]) | (~wmask[2] & klo_q);
    end
  end

  // Read mux; unimplemented numbers and write-only fields read as 0.
  always_comb begin
    csr_bus.csr_rdata = 32'h0;
    case (csr_bus.csr_num)
      CSR_CRMD:   csr_bus.csr_rdata = {23'b0, crmd_q};
      CSR_PRMD:   csr_bus.csr_rdata = {29'b0, prmd_q};
      CSR_ECFG:   csr_bus.csr_rdata = {19'b0, ecfg_q};
      CSR_ESTAT:  csr_bus.csr_rdata = {1'b0, estat_esub_q, estat_ecode_q, 3'b0, estat_low};
      CSR_ERA:    csr_bus.csr_rdata = era_q;
      CSR_BADV:   csr_bus.csr_rdata = badv_q;
      CSR_EENTRY: csr_bus.csr_rdata = {eentry_q, 6'b0};
      CSR_TID:    csr_bus.csr_rdata = tid_q;
      CSR_TCFG:   csr_bus.csr_rdata = 32'(tcfg_q);
      CSR_TVAL:   csr_bus.csr_rdata = 32'(tval_q);
      CSR_LLBCTL: csr_bus.csr_rdata = {29'b0, klo_q, 1'b0, llbit_q};
      default:    csr_bus.csr_rdata = 32'h0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++)
      if (csr_bus.csr_num == 14'(CSR_SAVE0 + i))
        csr_bus.csr_rdata = save_q[i];
  end

endmodule

// File: tb/tb_csr_file_gen.sv
// Directed self-checking bench for csr_file_gen. dut_a uses the default
// parameters; dut_b uses SAVE_NUM=2, TIMER_W=16 for the narrow-config cases.
module tb_csr_file_gen;

  localparam logic [13:0] CRMD = 14'h000, PRMD = 14'h001, ECFG = 14'h004, ESTAT = 14'h005;
  localparam logic [13:0] ERA = 14'h006, BADV = 14'h007, TID = 14'h040, TCFG = 14'h041;
  localparam logic [13:0] TVAL = 14'h042, TICLR = 14'h044, LLBCTL = 14'h060;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        excp_flush = 1'b0, ertn_flush = 1'b0, va_err = 1'b0;
  logic [5:0]  ecode = '0;
  logic [8:0]  esubcode = '0;
  logic [31:0] epc = '0, err_va = '0;
  logic        llbit_set = 1'b0, llbit_clr = 1'b0;
  logic [7:0]  hard_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic        llbit, has_int;
  logic [31:0] era, eentry, cnt_id;
  logic [63:0] cnt_value;
  logic        llbit_b, has_int_b;
  logic [31:0] era_b, eentry_b, cnt_id_b;
  logic [63:0] cnt_value_b;
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_fail = 0;

  csr_file_gen_if bus_a ();
  csr_file_gen_if bus_b ();

  always #5 clk = ~clk;

  csr_file_gen dut_a (
    .clk(clk), .reset(reset), .csr_bus(bus_a.slave),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode), .esubcode(esubcode),
    .epc(epc), .va_err(va_err), .err_va(err_va), .llbit_set(llbit_set), .llbit_clr(llbit_clr),
    .llbit(llbit), .era(era), .eentry(eentry), .hard_int_in(hard_int_in),
    .ipi_int_in(ipi_int_in), .has_int(has_int), .cnt_value(cnt_value), .cnt_id(cnt_id)
  );

  csr_file_gen #(.SAVE_NUM(2), .TIMER_W(16)) dut_b (
    .clk(clk), .reset(reset), .csr_bus(bus_b.slave),
    .excp_flush(1'b0), .ertn_flush(1'b0), .ecode(6'h0), .esubcode(9'h0),
    .epc(32'h0), .va_err(1'b0), .err_va(32'h0), .llbit_set(1'b0), .llbit_clr(1'b0),
    .llbit(llbit_b), .era(era_b), .eentry(eentry_b), .hard_int_in(8'h0),
    .ipi_int_in(1'b0), .has_int(has_int_b), .cnt_value(cnt_value_b), .cnt_id(cnt_id_b)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CSR write cycle on the selected DUT.
  task automatic applyStimulus(input bit second, input logic [13:0] num,
                               input logic [31:0] mask, input logic [31:0] data);
    if (second) begin
      bus_b.csr_we = 1'b1; bus_b.csr_num = num; bus_b.csr_wmask = mask; bus_b.csr_wdata = data;
    end else begin
      bus_a.csr_we = 1'b1; bus_a.csr_num = num; bus_a.csr_wmask = mask; bus_a.csr_wdata = data;
    end
    tick();
    bus_a.csr_we = 1'b0;
    bus_b.csr_we = 1'b0;
  endtask

  task automatic readCsr(input bit second, input logic [13:0] num, output logic [31:0] data);
    if (second) bus_b.csr_num = num;
    else        bus_a.csr_num = num;
    #1;
    data = second ? bus_b.csr_rdata : bus_a.csr_rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_a.csr_we = 1'b0; bus_a.csr_num = '0; bus_a.csr_wmask = '0; bus_a.csr_wdata = '0;
    bus_b.csr_we = 1'b0; bus_b.csr_num = '0; bus_b.csr_wmask = '0; bus_b.csr_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and the free-running counter
    checkOutput("cnt_at_reset", cnt_value, 64'd0);
    tick();
    checkOutput("cnt_plus1", cnt_value, 64'd1);
    tick();
    checkOutput("cnt_plus2", cnt_value, 64'd2);
    readCsr(0, CRMD, rd);  checkOutput("crmd_reset", rd, 64'h8);
    readCsr(0, ESTAT, rd); checkOutput("estat_reset", rd, 64'h0);
    readCsr(0, TCFG, rd);  checkOutput("tcfg_reset", rd, 64'h0);
    checkOutput("has_int_reset", has_int, 64'h0);
    checkOutput("llbit_reset", llbit, 64'h0);
    checkOutput("cnt_id_reset", cnt_id, 64'h0);

    // Periodic timer, InitVal=2
    $display("[TB] periodic timer");
    applyStimulus(0, TCFG, 32'hFFFFFFFF, 32'hB);
    readCsr(0, TVAL, rd); checkOutput("tval_load", rd, 64'd8);
    for (int k = 7; k >= 0; k--) begin
      tick();
      readCsr(0, TVAL, rd); checkOutput($sformatf("tval_%0d", k), rd, 64'(k));
    end
    readCsr(0, ESTAT, rd); checkOutput("ti_before_expiry", rd, 64'h0);
    tick();
    readCsr(0, ESTAT, rd); checkOutput("ti_on_expiry", rd, 64'h800);
    readCsr(0, TVAL, rd);  checkOutput("tval_reload", rd, 64'd8);
    applyStimulus(0, TICLR, 32'h1, 32'h1);
    readCsr(0, ESTAT, rd); checkOutput("ti_cleared", rd, 64'h0);
    readCsr(0, TCFG, rd);  checkOutput("tcfg_periodic", rd, 64'hB);
    readCsr(0, TICLR, rd); checkOutput("ticlr_reads0", rd, 64'h0);

    // One-shot timer
    $display("[TB] one-shot timer");
    applyStimulus(0, TCFG, 32'hFFFFFFFF, 32'h9);
    repeat (8) tick();
    readCsr(0, TVAL, rd);  checkOutput("oneshot_tval0", rd, 64'd0);
    tick();
    readCsr(0, ESTAT, rd); checkOutput("oneshot_ti", rd, 64'h800);
    readCsr(0, TCFG, rd);  checkOutput("oneshot_en_off", rd, 64'h8);
    tick();
    readCsr(0, TVAL, rd);  checkOutput("oneshot_tval_hold", rd, 64'd0);

    // Timer interrupt enabled, then exception entry
    $display("[TB] interrupt and exception");
    applyStimulus(0, CRMD, 32'h4, 32'h4);
    readCsr(0, CRMD, rd); checkOutput("crmd_ie_set", rd, 64'hC);
    applyStimulus(0, ECFG, 32'hFFFFFFFF, 32'h800);
    checkOutput("has_int_on", has_int, 64'h1);
    excp_flush = 1'b1; ecode = 6'h0; esubcode = 9'h0; epc = 32'h1c000100;
    tick();
    excp_flush = 1'b0;
    readCsr(0, CRMD, rd); checkOutput("excp_crmd", rd, 64'h8);
    readCsr(0, PRMD, rd); checkOutput("excp_prmd", rd, 64'h4);
    checkOutput("excp_era", era, 64'h1c000100);
    checkOutput("has_int_off", has_int, 64'h0);

    // BADV capture beats a same-cycle BADV write
    excp_flush = 1'b1; va_err = 1'b1; err_va = 32'hDEAD0003; ecode = 6'h9; epc = 32'h1c000200;
    applyStimulus(0, BADV, 32'hFFFFFFFF, 32'h1234);
    excp_flush = 1'b0; va_err = 1'b0;
    readCsr(0, BADV, rd);  checkOutput("badv_capture", rd, 64'hDEAD0003);
    readCsr(0, ESTAT, rd); checkOutput("estat_ecode", (rd >> 16) & 32'h3F, 64'h9);
    readCsr(0, ERA, rd);   checkOutput("era_second", rd, 64'h1c000200);
    applyStimulus(0, BADV, 32'hFFFF0000, 32'h12345678);
    readCsr(0, BADV, rd);  checkOutput("badv_masked", rd, 64'h12340003);

    // LLBit and KLO
    $display("[TB] llbit");
    llbit_set = 1'b1; tick(); llbit_set = 1'b0;
    checkOutput("llbit_set", llbit, 64'h1);
    applyStimulus(0, LLBCTL, 32'h4, 32'h4);
    readCsr(0, LLBCTL, rd); checkOutput("llbctl_klo", rd, 64'h5);
    ertn_flush = 1'b1; tick(); ertn_flush = 1'b0;
    checkOutput("llbit_kept_klo", llbit, 64'h1);
    readCsr(0, LLBCTL, rd); checkOutput("klo_cleared", rd, 64'h1);
    ertn_flush = 1'b1; tick(); ertn_flush = 1'b0;
    checkOutput("llbit_ertn_clr", llbit, 64'h0);
    llbit_set = 1'b1; tick(); llbit_set = 1'b0;
    applyStimulus(0, LLBCTL, 32'h2, 32'h2);
    checkOutput("llbit_wcllb", llbit, 64'h0);
    readCsr(0, LLBCTL, rd); checkOutput("llbctl_after_wcllb", rd, 64'h0);
    llbit_set = 1'b1; tick();
    llbit_clr = 1'b1; tick();
    llbit_set = 1'b0; llbit_clr = 1'b0;
    checkOutput("llbit_clr_over_set", llbit, 64'h0);

    // Interrupt line sampling
    applyStimulus(0, TICLR, 32'h1, 32'h1);
    hard_int_in = 8'hA5; ipi_int_in = 1'b1;
    tick();
    hard_int_in = 8'h0; ipi_int_in = 1'b0;
    readCsr(0, ESTAT, rd); checkOutput("estat_int_lines", rd & 32'h1FFF, 64'h1294);

    // Field masks, SAVE, TID, unimplemented number
    applyStimulus(0, ECFG, 32'hFFFFFFFF, 32'hFFFFFFFF);
    readCsr(0, ECFG, rd); checkOutput("ecfg_mask", rd, 64'h1BFF);
    applyStimulus(0, 14'h033, 32'hFFFFFFFF, 32'h5A5A5A5A);
    readCsr(0, 14'h033, rd); checkOutput("save3", rd, 64'h5A5A5A5A);
    readCsr(0, 14'h034, rd); checkOutput("save4_absent", rd, 64'h0);
    applyStimulus(0, TID, 32'hFFFFFFFF, 32'hCAFE);
    checkOutput("cnt_id_tid", cnt_id, 64'hCAFE);
    readCsr(0, 14'h003, rd); checkOutput("unimpl_reads0", rd, 64'h0);

    // Narrow configuration
    $display("[TB] SAVE_NUM=2 TIMER_W=16");
    applyStimulus(1, 14'h032, 32'hFFFFFFFF, 32'hFFFFFFFF);
    readCsr(1, 14'h032, rd); checkOutput("b_save2_dropped", rd, 64'h0);
    applyStimulus(1, 14'h031, 32'hFFFFFFFF, 32'h600D);
    readCsr(1, 14'h031, rd); checkOutput("b_save1", rd, 64'h600D);
    applyStimulus(1, TCFG, 32'hFFFFFFFF, 32'hFFFFFFFF);
    readCsr(1, TCFG, rd); checkOutput("b_tcfg", rd, 64'hFFFF);
    readCsr(1, TVAL, rd); checkOutput("b_tval", rd, 64'hFFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
